// File: rtl/mem_block_xfer.sv
// Block-transfer requester: turns one cache block request into
// per-word commands on the single-port block memory.
module mem_block_xfer #(
  parameter int WORD_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 2,
  parameter int OFFSET_BITS     = $clog2(WORDS_PER_BLOCK),
  parameter int BLOCK_ADDR_BITS = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_write,
  input  logic [BLOCK_ADDR_BITS-1:0]            req_block_addr,
  input  logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] req_wdata,
  output logic                                  resp_valid,
  output logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] resp_rdata,
  output logic                                  busy,
  output logic                                  mem_write_en,
  output logic                                  mem_read_en,
  output logic [BLOCK_ADDR_BITS-1:0]            mem_block_addr,
  output logic [OFFSET_BITS-1:0]                mem_word_offset,
  output logic [WORD_WIDTH-1:0]                 mem_data_in,
  input  logic [WORD_WIDTH-1:0]                 mem_data_out
);

  localparam int BW = WORD_WIDTH * WORDS_PER_BLOCK;
  localparam logic [OFFSET_BITS-1:0] LAST =
    OFFSET_BITS'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t                     state;
  state_t                     state_nx;
  logic [OFFSET_BITS-1:0]     cnt;
  logic [OFFSET_BITS-1:0]     cnt_nx;
  logic                       wr_q;
  logic [BLOCK_ADDR_BITS-1:0] addr_q;
  logic [BW-1:0]              wdata_q;

  logic                       issue;
  logic                       issue_wr;
  logic [BLOCK_ADDR_BITS-1:0] issue_addr;
  logic [BW-1:0]              issue_blk;
  logic [WORD_WIDTH-1:0]      issue_word;

  // Next state, word counter and the command to launch on this edge
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    issue    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_nx = ISSUE;
          cnt_nx   = '0;
          issue    = 1'b1;
        end
      end
      ISSUE: begin
        state_nx = WAIT;
      end
      WAIT: begin
        if (cnt == LAST) begin
          state_nx = RESP;
        end else begin
          state_nx = ISSUE;
          cnt_nx   = cnt + 1'b1;
          issue    = 1'b1;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // On the accept edge the latches are not loaded yet, so the
  // command is built straight from the request inputs
  always_comb begin
    issue_wr   = wr_q;
    issue_addr = addr_q;
    issue_blk  = wdata_q;
    if (state == IDLE) begin
      issue_wr   = req_write;
      issue_addr = req_block_addr;
      issue_blk  = req_wdata;
    end
    issue_word =
      issue_blk[int'(cnt_nx)*WORD_WIDTH +: WORD_WIDTH];
  end

  // State register and word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Request latch; later input changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req_valid) begin
      wr_q    <= req_write;
      addr_q  <= req_block_addr;
      wdata_q <= req_wdata;
    end
  end

  // Registered memory command; enables last one cycle, the
  // address and data stay put through the deaf cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read_en     <= 1'b0;
      mem_write_en    <= 1'b0;
      mem_block_addr  <= '0;
      mem_word_offset <= '0;
      mem_data_in     <= '0;
    end else begin
      mem_read_en  <= issue && !issue_wr;
      mem_write_en <= issue && issue_wr;
      if (issue) begin
        mem_block_addr  <= issue_addr;
        mem_word_offset <= cnt_nx;
        if (issue_wr) begin
          mem_data_in <= issue_word;
        end
      end
    end
  end

  // Fill data is captured at the edge closing the WAIT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata <= '0;
    end else if (state == WAIT && !wr_q) begin
      resp_rdata[int'(cnt)*WORD_WIDTH +: WORD_WIDTH] <= mem_data_out;
    end
  end

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);

endmodule
